mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
Multicycle main controller for the MIPS-subset CPU core. It consumes the opcode/funct fields of the instruction register and produces every datapath strobe and mux select: PC enable, IR load, register-file write, memory access, and ALU operand/operation selects. It sits directly beside the datapath as its sole sequencer. It adds a memory-ready handshake so fetch and load/store states can stall on a slow memory.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
op  in  6  instr[31:26]
funct  in  6  instr[5:0]
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access requested this cycle
iord  out  1  0=address from PC, 1=address from ALUOut
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
pc_write  out  1  unconditional PC load
branch  out  1  PC load qualified by ALU Zero
pc_src  out  2  00=ALUResult, 01=ALUOut, 10=jump target
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  00=B, 01=4, 10=SignImm, 11=SignImm<<2
alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALUOut, 1=memory data
reg_write  out  1  register-file write enable
illegal_op  out  1  one-cycle pulse on unsupported op/funct
state_o  out  4  current state (debug)
instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset (async, active-low): state=IDLE(0), instr_count=0. In IDLE all outputs are 0. IDLE always goes to FETCH on the next clk.
- Outputs are decoded from the state register. Signals not listed for a state are 0. In every state, mem_write, ir_write and pc_write additionally require mem_ready where noted.
- State encoding: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, ALUWB 8, BRANCH 9, ADDIEX 10, ADDIWB 11, JUMP 12. Codes 13-15 go to FETCH.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=010, pc_src=00.
  - ir_write=pc_write=mem_ready.
  - Stay in FETCH while !mem_ready; otherwise go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_control=010 (branch target into ALUOut). Next state by op:
  - 100011 lw or 101011 sw -> MEMADR
  - 000000 -> EXEC
  - 000100 beq -> BRANCH
  - 001000 addi -> ADDIEX
  - 000010 j -> JUMP (feature only)
  - any other op: illegal_op=1, go to FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, add. lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_req=1, iord=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
- MEMWR: mem_req=1, iord=1, mem_write=mem_ready. Hold until mem_ready, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00. alu_control from funct: 100000 add 010, 100010 sub 110, 100100 and 000, 100101 or 001, 101010 slt 111.
  - Unknown funct: alu_control=010, illegal_op=1, go to FETCH (no writeback).
  - Known funct: go to ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_control=110, branch=1, pc_src=01. Then FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, add. Then ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
- instr_count increments by 1 on the clock that leaves MEMWB, MEMWR (with mem_ready), ALUWB, BRANCH, ADDIWB or JUMP.
  - Not incremented on illegal aborts.
  - Wraps modulo 2^CNT_W.
- Latencies with zero wait states: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3. Each stall cycle on mem_ready adds 1.
- Reset asserted mid-instruction aborts immediately: no further strobes, and the sequence resumes at IDLE.
- op/funct are sampled only in DECODE/MEMADR/EXEC. They must be stable from the IR after FETCH.

Optional Feature:
MC_JUMP_EN
- Defined: op 000010 in DECODE goes to JUMP. JUMP drives pc_write=1, pc_src=10, then FETCH, and counts as retired.
- Undefined: JUMP state is not built, op 000010 is illegal (illegal_op pulse), and pc_src never equals 10.

Test Plan:
- Reset held 3 cycles then released -> state_o=0, all outputs 0, instr_count=0; next cycle state_o=1, mem_req=1.
- lw (op 100011), mem_ready low 2 cycles in FETCH and in MEMRD -> ir_write pulses once on the ready cycle; sequence 1,2,3,4,5,1; reg_write=1 and mem_to_reg=1 in state 5; instr_count +1; 7 cycles total.
- R-type op 0, funct 101010 -> state 7 with alu_control=111, alu_src_b=00; state 8 with reg_dst=1, reg_write=1; count +1.
- beq op 000100, mem_ready=1 -> state 9 with branch=1, pc_src=01, alu_control=110; 3 cycles; count +1.
- op 111111 and, separately, R-type funct 000001 -> illegal_op one-cycle pulse, return to FETCH, no reg_write, count unchanged.
- sw with rst_n asserted in MEMWR before mem_ready -> mem_write never asserted, state_o=0; j op 000010 with MC_JUMP_EN defined -> pc_write=1, pc_src=10; with it undefined -> illegal_op pulse.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// -----------------------------------------------------------------------------
// mc_ctrl_if
// Bundles the signals between the multicycle main controller and the datapath.
//   master : controller side. It receives op/funct/mem_ready and drives every
//            strobe, select, debug state and the retired-instruction count.
//   slave  : datapath side, with the opposite directions.
// Parameter CNT_W is the width of the retired-instruction counter.
// -----------------------------------------------------------------------------
interface mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             mem_ready;
    logic             mem_req;
    logic             iord;
    logic             mem_write;
    logic             ir_write;
    logic             pc_write;
    logic             branch;
    logic [1:0]       pc_src;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_control;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             illegal_op;
    logic [3:0]       state_o;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  op, funct, mem_ready,
        output mem_req, iord, mem_write, ir_write, pc_write, branch, pc_src,
               alu_src_a, alu_src_b, alu_control, reg_dst, mem_to_reg,
               reg_write, illegal_op, state_o, instr_count
    );

    modport slave (
        output op, funct, mem_ready,
        input  mem_req, iord, mem_write, ir_write, pc_write, branch, pc_src,
               alu_src_a, alu_src_b, alu_control, reg_dst, mem_to_reg,
               reg_write, illegal_op, state_o, instr_count
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm
// Multicycle main controller for the MIPS-subset core. It decodes the IR
// op/funct fields and sequences the datapath, stalling fetch and load/store
// states on a memory-ready handshake.
//
// Ports:
//   clk    : clock
//   rst_n  : asynchronous, active-low reset (state -> IDLE, count -> 0)
//   bus    : mc_ctrl_if.master
//            in  : op, funct, mem_ready
//            out : mem_req, iord, mem_write, ir_write, pc_write, branch,
//                  pc_src, alu_src_a, alu_src_b, alu_control, reg_dst,
//                  mem_to_reg, reg_write, illegal_op, state_o, instr_count
//
// Parameter CNT_W : width of the retired-instruction counter (wraps).
//
// Build option MC_JUMP_EN : when defined, op 000010 (j) is decoded into the
// JUMP state. When undefined, that state is not built and j is illegal.
// -----------------------------------------------------------------------------
module mc_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    mc_ctrl_if.master  bus
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;
`ifdef MC_JUMP_EN
    localparam logic [3:0] S_JUMP   = 4'd12;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MC_JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    logic [3:0]       state;
    logic [3:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (retire) begin
                cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.state_o     = state;
    assign bus.instr_count = cnt;

    // Outputs are decoded from the state register; only the memory strobes
    // and the op/funct-dependent fields look at live inputs.
    always_comb begin
        bus.mem_req     = 1'b0;
        bus.iord        = 1'b0;
        bus.mem_write   = 1'b0;
        bus.ir_write    = 1'b0;
        bus.pc_write    = 1'b0;
        bus.branch      = 1'b0;
        bus.pc_src      = 2'b00;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = 2'b00;
        bus.alu_control = 3'b000;
        bus.reg_dst     = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.reg_write   = 1'b0;
        bus.illegal_op  = 1'b0;
        retire          = 1'b0;
        state_nxt       = S_FETCH;

        case (state)
            S_IDLE: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                bus.mem_req     = 1'b1;
                bus.alu_src_b   = 2'b01;
                bus.alu_control = ALU_ADD;
                // IR load and PC+4 commit only on the cycle memory delivers.
                bus.ir_write    = bus.mem_ready;
                bus.pc_write    = bus.mem_ready;
                state_nxt       = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                bus.alu_src_b   = 2'b11;
                bus.alu_control = ALU_ADD;
                case (bus.op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXEC;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_ADDI:      state_nxt = S_ADDIEX;
`ifdef MC_JUMP_EN
                    OP_J:         state_nxt = S_JUMP;
`endif
                    default: begin
                        bus.illegal_op = 1'b1;
                        state_nxt      = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = 2'b10;
                bus.alu_control = ALU_ADD;
                state_nxt       = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                state_nxt   = bus.mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                retire         = 1'b1;
                state_nxt      = S_FETCH;
            end
            S_MEMWR: begin
                bus.mem_req   = 1'b1;
                bus.iord      = 1'b1;
                bus.mem_write = bus.mem_ready;
                retire        = bus.mem_ready;
                state_nxt     = bus.mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b00;
                state_nxt     = S_ALUWB;
                case (bus.funct)
                    FN_ADD: bus.alu_control = ALU_ADD;
                    FN_SUB: bus.alu_control = ALU_SUB;
                    FN_AND: bus.alu_control = ALU_AND;
                    FN_OR:  bus.alu_control = ALU_OR;
                    FN_SLT: bus.alu_control = ALU_SLT;
                    default: begin
                        // Abort without writeback; the instruction does not retire.
                        bus.alu_control = ALU_ADD;
                        bus.illegal_op  = 1'b1;
                        state_nxt       = S_FETCH;
                    end
                endcase
            end
            S_ALUWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                retire        = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = 2'b00;
                bus.alu_control = ALU_SUB;
                bus.branch      = 1'b1;
                bus.pc_src      = 2'b01;
                retire          = 1'b1;
                state_nxt       = S_FETCH;
            end
            S_ADDIEX: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = 2'b10;
                bus.alu_control = ALU_ADD;
                state_nxt       = S_ADDIWB;
            end
            S_ADDIWB: begin
                bus.reg_write = 1'b1;
                retire        = 1'b1;
                state_nxt     = S_FETCH;
            end
`ifdef MC_JUMP_EN
            S_JUMP: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = 2'b10;
                retire       = 1'b1;
                state_nxt    = S_FETCH;
            end
`endif
            default: begin
                // Unused encodings recover through FETCH.
                state_nxt = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl_fsm
// Cycle-by-cycle directed bench for mc_ctrl_fsm. Each record gives the inputs
// for one clock cycle and the state, control word and retired count expected
// during that cycle. A narrow counter (CNT_W=4) makes wrap-around reachable.
// Honours MC_JUMP_EN for the j instruction expectations.
// -----------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

    localparam int CNT_W = 4;

    typedef struct {
        logic       rst_n;
        logic [5:0] op;
        logic [5:0] funct;
        logic       rdy;
        logic [3:0] st;
        logic [17:0] ctl;
        logic [3:0] cnt;
    } vec_t;

    logic clk;
    logic rst_n;

    mc_ctrl_if #(.CNT_W(CNT_W)) bus ();

    mc_ctrl_fsm #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic [17:0] obs;
    assign obs = {bus.mem_req, bus.iord, bus.mem_write, bus.ir_write,
                  bus.pc_write, bus.branch, bus.pc_src, bus.alu_src_a,
                  bus.alu_src_b, bus.alu_control, bus.reg_dst,
                  bus.mem_to_reg, bus.reg_write, bus.illegal_op};

    function automatic logic [17:0] mk(
        input logic mreq, input logic iord, input logic mw, input logic irw,
        input logic pcw, input logic br, input logic [1:0] pcs,
        input logic asa, input logic [1:0] asb, input logic [2:0] aluc,
        input logic rd, input logic m2r, input logic rw, input logic ill);
        return {mreq, iord, mw, irw, pcw, br, pcs, asa, asb, aluc, rd, m2r, rw, ill};
    endfunction

    function automatic vec_t row(input logic r, input logic [5:0] o,
                                 input logic [5:0] f, input logic rd,
                                 input logic [3:0] s, input logic [17:0] c,
                                 input logic [3:0] n);
        vec_t v;
        v.rst_n = r; v.op = o; v.funct = f; v.rdy = rd;
        v.st = s; v.ctl = c; v.cnt = n;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run_row(input string tag, input vec_t v);
        @(negedge clk);
        rst_n         = v.rst_n;
        bus.op        = v.op;
        bus.funct     = v.funct;
        bus.mem_ready = v.rdy;
        #1;
        chk({tag, ".state"}, 32'(bus.state_o), 32'(v.st));
        chk({tag, ".ctl"},   32'(obs),         32'(v.ctl));
        chk({tag, ".cnt"},   32'(bus.instr_count), 32'(v.cnt));
    endtask

    // Hand-derived control words, packed as
    // {mem_req,iord,mem_write,ir_write,pc_write,branch,pc_src,alu_src_a,
    //  alu_src_b,alu_control,reg_dst,mem_to_reg,reg_write,illegal_op}
    logic [17:0] Z, F_RDY, F_STL, DEC, DEC_ILL, MADR, MRD, MWB, MWR_RDY,
                 MWR_STL, EX_SLT, EX_ILL, AWB, BR, AIWB, JMP;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                           ADDI = 6'b001000, RT = 6'b000000, J = 6'b000010,
                           BAD = 6'b111111;

    vec_t tbl[$];

    initial begin
        rst_n         = 1'b0;
        bus.op        = 6'd0;
        bus.funct     = 6'd0;
        bus.mem_ready = 1'b0;

        Z       = '0;
        F_RDY   = mk(1,0,0,1,1,0,2'b00,0,2'b01,3'b010,0,0,0,0);
        F_STL   = mk(1,0,0,0,0,0,2'b00,0,2'b01,3'b010,0,0,0,0);
        DEC     = mk(0,0,0,0,0,0,2'b00,0,2'b11,3'b010,0,0,0,0);
        DEC_ILL = mk(0,0,0,0,0,0,2'b00,0,2'b11,3'b010,0,0,0,1);
        MADR    = mk(0,0,0,0,0,0,2'b00,1,2'b10,3'b010,0,0,0,0);
        MRD     = mk(1,1,0,0,0,0,2'b00,0,2'b00,3'b000,0,0,0,0);
        MWB     = mk(0,0,0,0,0,0,2'b00,0,2'b00,3'b000,0,1,1,0);
        MWR_RDY = mk(1,1,1,0,0,0,2'b00,0,2'b00,3'b000,0,0,0,0);
        MWR_STL = mk(1,1,0,0,0,0,2'b00,0,2'b00,3'b000,0,0,0,0);
        EX_SLT  = mk(0,0,0,0,0,0,2'b00,1,2'b00,3'b111,0,0,0,0);
        EX_ILL  = mk(0,0,0,0,0,0,2'b00,1,2'b00,3'b010,0,0,0,1);
        AWB     = mk(0,0,0,0,0,0,2'b00,0,2'b00,3'b000,1,0,1,0);
        BR      = mk(0,0,0,0,0,1,2'b01,1,2'b00,3'b110,0,0,0,0);
        AIWB    = mk(0,0,0,0,0,0,2'b00,0,2'b00,3'b000,0,0,1,0);
        JMP     = mk(0,0,0,0,1,0,2'b10,0,2'b00,3'b000,0,0,0,0);

        // reset held 3 cycles, then released: IDLE with everything low
        tbl.push_back(row(0, RT, 0, 1, 0, Z, 0));
        tbl.push_back(row(0, RT, 0, 1, 0, Z, 0));
        tbl.push_back(row(0, RT, 0, 1, 0, Z, 0));
        tbl.push_back(row(1, RT, 0, 1, 0, Z, 0));
        // lw: one stall in FETCH, one in MEMRD -> 7 cycles
        tbl.push_back(row(1, LW, 0, 0, 1, F_STL, 0));
        tbl.push_back(row(1, LW, 0, 1, 1, F_RDY, 0));
        tbl.push_back(row(1, LW, 0, 1, 2, DEC,   0));
        tbl.push_back(row(1, LW, 0, 1, 3, MADR,  0));
        tbl.push_back(row(1, LW, 0, 0, 4, MRD,   0));
        tbl.push_back(row(1, LW, 0, 1, 4, MRD,   0));
        tbl.push_back(row(1, LW, 0, 1, 5, MWB,   0));
        // R-type slt
        tbl.push_back(row(1, RT, 6'b101010, 1, 1, F_RDY,  1));
        tbl.push_back(row(1, RT, 6'b101010, 1, 2, DEC,    1));
        tbl.push_back(row(1, RT, 6'b101010, 1, 7, EX_SLT, 1));
        tbl.push_back(row(1, RT, 6'b101010, 1, 8, AWB,    1));
        // beq
        tbl.push_back(row(1, BEQ, 0, 1, 1, F_RDY, 2));
        tbl.push_back(row(1, BEQ, 0, 1, 2, DEC,   2));
        tbl.push_back(row(1, BEQ, 0, 1, 9, BR,    2));
        // addi
        tbl.push_back(row(1, ADDI, 0, 1, 1,  F_RDY, 3));
        tbl.push_back(row(1, ADDI, 0, 1, 2,  DEC,   3));
        tbl.push_back(row(1, ADDI, 0, 1, 10, MADR,  3));
        tbl.push_back(row(1, ADDI, 0, 1, 11, AIWB,  3));
        // illegal op: pulse in DECODE, straight back to FETCH, no retire
        tbl.push_back(row(1, BAD, 0, 1, 1, F_RDY,   4));
        tbl.push_back(row(1, BAD, 0, 1, 2, DEC_ILL, 4));
        // illegal funct: pulse in EXEC, no ALUWB
        tbl.push_back(row(1, RT, 6'b000001, 1, 1, F_RDY,  4));
        tbl.push_back(row(1, RT, 6'b000001, 1, 2, DEC,    4));
        tbl.push_back(row(1, RT, 6'b000001, 1, 7, EX_ILL, 4));
        // sw with one stall in MEMWR
        tbl.push_back(row(1, SW, 0, 1, 1, F_RDY,   4));
        tbl.push_back(row(1, SW, 0, 1, 2, DEC,     4));
        tbl.push_back(row(1, SW, 0, 1, 3, MADR,    4));
        tbl.push_back(row(1, SW, 0, 0, 6, MWR_STL, 4));
        tbl.push_back(row(1, SW, 0, 1, 6, MWR_RDY, 4));
        tbl.push_back(row(1, SW, 0, 1, 1, F_RDY,   5));

        foreach (tbl[i]) run_row($sformatf("row%0d", i), tbl[i]);

        // sw interrupted by reset while MEMWR waits on memory
        run_row("rst_sw.dec",  row(1, SW, 0, 1, 2, DEC,     5));
        run_row("rst_sw.adr",  row(1, SW, 0, 1, 3, MADR,    5));
        run_row("rst_sw.wr",   row(1, SW, 0, 0, 6, MWR_STL, 5));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_sw.async_state", 32'(bus.state_o), 32'd0);
        chk("rst_sw.async_ctl",   32'(obs),         32'd0);
        chk("rst_sw.async_cnt",   32'(bus.instr_count), 32'd0);
        run_row("rst_sw.hold", row(0, SW, 0, 1, 0, Z, 0));
        run_row("rst_sw.rel",  row(1, SW, 0, 1, 0, Z, 0));

        // counter wrap: 16 back-to-back beq on a 4-bit counter
        for (int k = 0; k < 16; k++) begin
            run_row($sformatf("wrap%0d.f", k), row(1, BEQ, 0, 1, 1, F_RDY, 4'(k)));
            run_row($sformatf("wrap%0d.d", k), row(1, BEQ, 0, 1, 2, DEC,   4'(k)));
            run_row($sformatf("wrap%0d.b", k), row(1, BEQ, 0, 1, 9, BR,    4'(k)));
        end

        // j after the wrap: count back at 0
        run_row("j.fetch", row(1, J, 0, 1, 1, F_RDY, 0));
`ifdef MC_JUMP_EN
        run_row("j.dec",   row(1, J, 0, 1, 2,  DEC,   0));
        run_row("j.jump",  row(1, J, 0, 1, 12, JMP,   0));
        run_row("j.after", row(1, J, 0, 1, 1,  F_RDY, 1));
`else
        run_row("j.dec",   row(1, J, 0, 1, 2, DEC_ILL, 0));
        run_row("j.after", row(1, J, 0, 1, 1, F_RDY,   0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
